// File: rtl/texture_loader_pkg.sv
// texture_loader_pkg: shared constants for the texture load sequencer.
//   - SDRAM source addresses and word counts of the bird, pipe and base
//     textures. These are also used to size the sprite_render RAMs.
//   - FSM state encodings, kept as plain logic constants so that older
//     consumers can use them.
//   - phase_cfg(): maps an FSM state to the source and length of the
//     fetch phase that state runs.
// Build option: TEXTURE_PIPE_TRUNC_EN. When defined, the pipe phase
// fetches only the first PIPE_KEEP_WORDS words, i.e. the rows that
// sprite_render actually displays.
package texture_loader_pkg;

  localparam int unsigned ADDR_W          = 24;
  localparam int unsigned DATA_W          = 16;
  localparam int unsigned CNT_W           = 16;
  localparam int unsigned OUT_W           = 4;
  localparam int unsigned MAX_OUTSTANDING = 4;

  localparam int unsigned BIRD_ADDR_W = 13;
  localparam int unsigned PIPE_ADDR_W = 16;
  localparam int unsigned BASE_ADDR_W = 14;

  localparam logic [ADDR_W-1:0] BIRD_SRC_ADDR = 24'h000000;
  localparam logic [ADDR_W-1:0] PIPE_SRC_ADDR = 24'h001482;
  localparam logic [ADDR_W-1:0] BASE_SRC_ADDR = 24'h00B0C2;

  localparam logic [CNT_W-1:0] BIRD_WORDS      = 16'd5250;
  localparam logic [CNT_W-1:0] PIPE_WORDS      = 16'd40000;
  localparam logic [CNT_W-1:0] PIPE_KEEP_WORDS = 16'd4000;
  localparam logic [CNT_W-1:0] BASE_WORDS      = 16'd4800;

`ifdef TEXTURE_PIPE_TRUNC_EN
  localparam logic [CNT_W-1:0] PIPE_LOAD_WORDS = PIPE_KEEP_WORDS;
`else
  localparam logic [CNT_W-1:0] PIPE_LOAD_WORDS = PIPE_WORDS;
`endif

  localparam int unsigned STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] ST_BIRD = 3'd1;
  localparam logic [STATE_W-1:0] ST_PIPE = 3'd2;
  localparam logic [STATE_W-1:0] ST_BASE = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE = 3'd4;

  // Source and length of one fetch phase.
  typedef struct packed {
    logic [ADDR_W-1:0] src_addr;
    logic [CNT_W-1:0]  count;
  } phase_cfg_t;

  // Non-asset states map to an empty phase, which keeps the channel idle.
  function automatic phase_cfg_t phase_cfg(input logic [STATE_W-1:0] state);
    phase_cfg_t cfg;
    cfg.src_addr = '0;
    cfg.count    = '0;
    case (state)
      ST_BIRD: begin
        cfg.src_addr = BIRD_SRC_ADDR;
        cfg.count    = BIRD_WORDS;
      end
      ST_PIPE: begin
        cfg.src_addr = PIPE_SRC_ADDR;
        cfg.count    = PIPE_LOAD_WORDS;
      end
      ST_BASE: begin
        cfg.src_addr = BASE_SRC_ADDR;
        cfg.count    = BASE_WORDS;
      end
      default: ;
    endcase
    return cfg;
  endfunction

endpackage

// File: rtl/texture_loader_fetch_channel.sv
// tex_fetch_channel: request/response bookkeeping for one fetch phase.
//   It issues up to i_count word reads starting at i_src_addr, with at
//   most MAX_OUTSTANDING reads accepted but not yet returned. It also
//   counts the returned words.
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_clear              latch i_src_addr / i_count and zero all counters
//   i_src_addr, i_count  configuration of the next phase (used on i_clear)
//   i_rd_gnt             request accepted this cycle
//   i_rd_valid           one read word returned
//   o_rd_req, o_rd_addr  registered read request and word address
//   o_rsp_fire_c         i_rd_valid accepted this cycle (stray returns dropped)
//   o_rsp_idx            index of the word being returned (pre-increment)
//   o_phase_done_c       every word returned and nothing in flight
module tex_fetch_channel
  import texture_loader_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic [ADDR_W-1:0] i_src_addr,
  input  logic [CNT_W-1:0]  i_count,
  input  logic              i_rd_gnt,
  input  logic              i_rd_valid,
  output logic              o_rd_req,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_rsp_fire_c,
  output logic [CNT_W-1:0]  o_rsp_idx,
  output logic              o_phase_done_c
);

  logic [ADDR_W-1:0] r_src;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_req_cnt;
  logic [CNT_W-1:0]  r_rsp_cnt;
  logic [OUT_W-1:0]  r_outstanding;
  logic              r_rd_req;
  logic [ADDR_W-1:0] r_rd_addr;

  logic              w_grant;
  logic              w_rsp_fire;
  logic [ADDR_W-1:0] w_src_nxt;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [CNT_W-1:0]  w_req_cnt_nxt;
  logic [CNT_W-1:0]  w_rsp_cnt_nxt;
  logic [OUT_W-1:0]  w_out_nxt;
  logic              w_rd_req_nxt;
  logic [ADDR_W-1:0] w_rd_addr_nxt;

  assign w_grant    = r_rd_req & i_rd_gnt;
  // A return with nothing in flight is a protocol violation (for example
  // a late return after reset), so it is ignored.
  assign w_rsp_fire = i_rd_valid & (r_outstanding != '0);

  // Next-state counters. Clear only happens when this phase is idle: no
  // request is pending and nothing is in flight.
  always_comb begin
    w_src_nxt     = r_src;
    w_count_nxt   = r_count;
    w_req_cnt_nxt = r_req_cnt;
    w_rsp_cnt_nxt = r_rsp_cnt;
    w_out_nxt     = r_outstanding;
    if (i_clear) begin
      w_src_nxt     = i_src_addr;
      w_count_nxt   = i_count;
      w_req_cnt_nxt = '0;
      w_rsp_cnt_nxt = '0;
      w_out_nxt     = '0;
    end else begin
      w_req_cnt_nxt = r_req_cnt + CNT_W'(w_grant);
      w_rsp_cnt_nxt = r_rsp_cnt + CNT_W'(w_rsp_fire);
      w_out_nxt     = r_outstanding + OUT_W'(w_grant) - OUT_W'(w_rsp_fire);
    end
  end

  // The request is computed one cycle ahead so that o_rd_req is a flop.
  // Without a grant, req_cnt holds and outstanding cannot rise, so a raised
  // request stays up.
  always_comb begin
    w_rd_req_nxt  = (w_req_cnt_nxt < w_count_nxt) &&
                    (w_out_nxt < OUT_W'(MAX_OUTSTANDING));
    w_rd_addr_nxt = w_src_nxt + ADDR_W'(w_req_cnt_nxt);
  end

  // Channel state registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_src         <= '0;
      r_count       <= '0;
      r_req_cnt     <= '0;
      r_rsp_cnt     <= '0;
      r_outstanding <= '0;
      r_rd_req      <= 1'b0;
      r_rd_addr     <= '0;
    end else begin
      r_src         <= w_src_nxt;
      r_count       <= w_count_nxt;
      r_req_cnt     <= w_req_cnt_nxt;
      r_rsp_cnt     <= w_rsp_cnt_nxt;
      r_outstanding <= w_out_nxt;
      r_rd_req      <= w_rd_req_nxt;
      r_rd_addr     <= w_rd_addr_nxt;
    end
  end

  assign o_rd_req       = r_rd_req;
  assign o_rd_addr      = r_rd_addr;
  assign o_rsp_fire_c   = w_rsp_fire;
  assign o_rsp_idx      = r_rsp_cnt;
  assign o_phase_done_c = (r_rsp_cnt == r_count) && (r_outstanding == '0);

endmodule

// File: rtl/texture_loader.sv
// texture_loader: streams the bird, pipe and base textures from SDRAM
// into the sprite_render texture RAMs after a start pulse.
// Ports:
//   bird_load_clk, rst_n    50 MHz clock (also the RAM write clock),
//                           asynchronous active-low reset
//   i_start                 one-cycle pulse that starts a full load
//                           (ignored while a load is running)
//   o_rd_req, o_rd_addr     SDRAM word read request; the request is held
//                           until granted
//   i_rd_gnt                request accepted this cycle
//   i_rd_valid, i_rd_data   in-order returned words
//   o_<asset>_load_en       one-cycle write strobe for the bird, pipe or
//                           base RAM
//   o_<asset>_load_addr     RAM write address, held between strobes
//   o_bird_load_data        load data bus shared by all three RAMs
//   o_busy, o_done          load in progress / sticky load complete
// Build option: TEXTURE_PIPE_TRUNC_EN limits the pipe phase to its first
// PIPE_KEEP_WORDS words. This is resolved in texture_loader_pkg.
module texture_loader
  import texture_loader_pkg::*;
(
  input  logic                   bird_load_clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  output logic                   o_rd_req,
  output logic [ADDR_W-1:0]      o_rd_addr,
  input  logic                   i_rd_gnt,
  input  logic                   i_rd_valid,
  input  logic [DATA_W-1:0]      i_rd_data,
  output logic                   o_bird_load_en,
  output logic [BIRD_ADDR_W-1:0] o_bird_load_addr,
  output logic                   o_pipe_load_en,
  output logic [PIPE_ADDR_W-1:0] o_pipe_load_addr,
  output logic                   o_base_load_en,
  output logic [BASE_ADDR_W-1:0] o_base_load_addr,
  output logic [DATA_W-1:0]      o_bird_load_data,
  output logic                   o_busy,
  output logic                   o_done
);

  logic [STATE_W-1:0]     r_state;
  logic [STATE_W-1:0]     w_state_nxt;
  logic                   r_busy;
  logic                   w_busy_nxt;
  logic                   r_done;
  logic                   w_done_nxt;
  logic                   w_clear;
  phase_cfg_t             w_cfg;

  logic                   w_rsp_fire;
  logic [CNT_W-1:0]       w_rsp_idx;
  logic                   w_phase_done;

  logic                   r_bird_en;
  logic                   r_pipe_en;
  logic                   r_base_en;
  logic [BIRD_ADDR_W-1:0] r_bird_addr;
  logic [PIPE_ADDR_W-1:0] r_pipe_addr;
  logic [BASE_ADDR_W-1:0] r_base_addr;
  logic [DATA_W-1:0]      r_load_data;

  // Counters are reloaded with the configuration of the state being entered.
  assign w_cfg = phase_cfg(w_state_nxt);

  tex_fetch_channel u_fetch (
    .i_clk          (bird_load_clk),
    .i_rst_n        (rst_n),
    .i_clear        (w_clear),
    .i_src_addr     (w_cfg.src_addr),
    .i_count        (w_cfg.count),
    .i_rd_gnt       (i_rd_gnt),
    .i_rd_valid     (i_rd_valid),
    .o_rd_req       (o_rd_req),
    .o_rd_addr      (o_rd_addr),
    .o_rsp_fire_c   (w_rsp_fire),
    .o_rsp_idx      (w_rsp_idx),
    .o_phase_done_c (w_phase_done)
  );

  // FSM state register.
  always_ff @(posedge bird_load_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic. An asset phase ends when all its words are back.
  always_comb begin
    w_state_nxt = r_state;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    w_clear     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_BIRD;
          w_busy_nxt  = 1'b1;
          w_done_nxt  = 1'b0;
          w_clear     = 1'b1;
        end
      end
      ST_BIRD: begin
        if (w_phase_done) begin
          w_state_nxt = ST_PIPE;
          w_clear     = 1'b1;
        end
      end
      ST_PIPE: begin
        if (w_phase_done) begin
          w_state_nxt = ST_BASE;
          w_clear     = 1'b1;
        end
      end
      ST_BASE: begin
        if (w_phase_done) begin
          w_state_nxt = ST_DONE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_clear     = 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Steer each accepted word to the RAM of the current phase, one cycle
  // later. Address and data hold between strobes.
  always_ff @(posedge bird_load_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bird_en   <= 1'b0;
      r_pipe_en   <= 1'b0;
      r_base_en   <= 1'b0;
      r_bird_addr <= '0;
      r_pipe_addr <= '0;
      r_base_addr <= '0;
      r_load_data <= '0;
    end else begin
      r_bird_en <= w_rsp_fire && (r_state == ST_BIRD);
      r_pipe_en <= w_rsp_fire && (r_state == ST_PIPE);
      r_base_en <= w_rsp_fire && (r_state == ST_BASE);
      if (w_rsp_fire) begin
        r_load_data <= i_rd_data;
      end
      if (w_rsp_fire && (r_state == ST_BIRD)) begin
        r_bird_addr <= BIRD_ADDR_W'(w_rsp_idx);
      end
      if (w_rsp_fire && (r_state == ST_PIPE)) begin
        r_pipe_addr <= PIPE_ADDR_W'(w_rsp_idx);
      end
      if (w_rsp_fire && (r_state == ST_BASE)) begin
        r_base_addr <= BASE_ADDR_W'(w_rsp_idx);
      end
    end
  end

  assign o_bird_load_en   = r_bird_en;
  assign o_pipe_load_en   = r_pipe_en;
  assign o_base_load_en   = r_base_en;
  assign o_bird_load_addr = r_bird_addr;
  assign o_pipe_load_addr = r_pipe_addr;
  assign o_base_load_addr = r_base_addr;
  assign o_bird_load_data = r_load_data;
  assign o_busy           = r_busy;
  assign o_done           = r_done;

endmodule

// File: tb/tb_texture_loader.sv
`timescale 1ns/1ps
module tb_texture_loader;

`ifdef TEXTURE_PIPE_TRUNC_EN
  localparam int PIPE_N = 4000;
`else
  localparam int PIPE_N = 40000;
`endif

  // Expected load sequence, taken from the asset table.
  int src_a [3] = '{32'h000000, 32'h001482, 32'h00B0C2};
  int cnt_a [3] = '{5250, PIPE_N, 4800};

  logic        bird_load_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        rd_req;
  logic [23:0] rd_addr;
  logic        rd_gnt = 1'b0;
  logic        rd_valid = 1'b0;
  logic [15:0] rd_data = 16'h0;
  logic        bird_en, pipe_en, base_en;
  logic [12:0] bird_addr;
  logic [15:0] pipe_addr;
  logic [13:0] base_addr;
  logic [15:0] load_data;
  logic        busy, done;

  texture_loader dut (
    .bird_load_clk    (bird_load_clk),
    .rst_n            (rst_n),
    .i_start          (start),
    .o_rd_req         (rd_req),
    .o_rd_addr        (rd_addr),
    .i_rd_gnt         (rd_gnt),
    .i_rd_valid       (rd_valid),
    .i_rd_data        (rd_data),
    .o_bird_load_en   (bird_en),
    .o_bird_load_addr (bird_addr),
    .o_pipe_load_en   (pipe_en),
    .o_pipe_load_addr (pipe_addr),
    .o_base_load_en   (base_en),
    .o_base_load_addr (base_addr),
    .o_bird_load_data (load_data),
    .o_busy           (busy),
    .o_done           (done)
  );

  always #10 bird_load_clk = ~bird_load_clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check_eq(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // SDRAM contents
  logic [15:0] mem [0:65535];

  // ---------------- SDRAM responder model ----------------
  typedef struct { int addr; longint due; } rsp_t;
  rsp_t   q[$];
  longint cyc = 0;
  longint last_due = 0;
  bit     gnt_en = 1'b1, valid_hold = 1'b0, rnd_mode = 1'b0;
  int     lat = 2;
  int     inject_cnt = 0;
  int     gnt_total = 0;
  int     rq_ph = 0, rq_idx = 0;
  bit     prev_req = 1'b0, prev_gnt = 1'b0;

  always @(posedge bird_load_clk) cyc++;

  always @(negedge bird_load_clk) begin
    longint k, due;
    bit g;
    int l;
    rsp_t r;
    k = cyc + 1;
    if (!rst_n) begin
      rd_gnt = 1'b0; rd_valid = 1'b0;
      q.delete(); last_due = 0;
      rq_ph = 0; rq_idx = 0; prev_req = 1'b0; prev_gnt = 1'b0;
    end else begin
      if (prev_req && !prev_gnt) check_eq("req_held_without_grant", longint'(rd_req), 1);
      rd_valid = 1'b0;
      rd_data  = 16'($urandom);
      if (inject_cnt > 0) begin
        rd_valid = 1'b1;
        inject_cnt--;
      end else if (!valid_hold && q.size() > 0 && q[0].due <= k) begin
        r = q.pop_front();
        rd_valid = 1'b1;
        rd_data  = mem[r.addr];
      end
      g = gnt_en && (!rnd_mode || $urandom_range(0, 9) < 7);
      rd_gnt = g && rd_req;
      if (rd_req && g) begin
        check_eq("rd_addr", longint'(rd_addr),
                 (rq_ph < 3) ? longint'(src_a[rq_ph] + rq_idx) : -1);
        l = rnd_mode ? int'($urandom_range(1, 4)) : lat;
        due = k + l;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        r.addr = int'(rd_addr);
        r.due  = due;
        q.push_back(r);
        gnt_total++;
        rq_idx++;
        while (rq_ph < 3 && rq_idx == cnt_a[rq_ph]) begin
          rq_ph++;
          rq_idx = 0;
        end
      end
      prev_req = rd_req;
      prev_gnt = rd_req && g;
    end
  end

  // ---------------- strobe checker / reference sequence ----------------
  int          ph = 0, idx = 0;
  int          scnt [3] = '{0, 0, 0};
  int          last_pipe = -1;
  int          done_pulses = 0;
  bit          prev_done = 1'b0;
  bit          seen = 1'b0;
  logic [15:0] last_data = 16'h0;
  bit          expect_none = 1'b0;
  int          stale_strobes = 0;

  always @(negedge bird_load_clk) begin
    int ns, a, ad;
    if (!rst_n) begin
      ph = 0; idx = 0; scnt = '{0, 0, 0}; last_pipe = -1;
      done_pulses = 0; prev_done = 1'b0; seen = 1'b0;
    end else begin
      ns = int'(bird_en) + int'(pipe_en) + int'(base_en);
      if (done && !prev_done) done_pulses++;
      prev_done = done;
      if (expect_none) begin
        if (ns != 0) stale_strobes++;
      end else if (ns > 1) begin
        check_eq("strobe_onehot", ns, 1);
      end else if (ns == 1) begin
        a  = bird_en ? 0 : (pipe_en ? 1 : 2);
        ad = (a == 0) ? int'(bird_addr) : ((a == 1) ? int'(pipe_addr) : int'(base_addr));
        scnt[a]++;
        if (a == 1) last_pipe = ad;
        if (ph > 2) begin
          check_eq("strobe_after_last_word", ns, 0);
        end else begin
          check_eq("strobe_asset", a, ph);
          check_eq("strobe_addr", ad, idx);
          check_eq("strobe_data", longint'(load_data), longint'(mem[src_a[ph] + idx]));
          idx++;
          if (idx == cnt_a[ph]) begin
            ph++;
            idx = 0;
          end
        end
        last_data = load_data;
        seen = 1'b1;
      end else if (seen) begin
        check_eq("data_hold", longint'(load_data), longint'(last_data));
      end
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    string name;
    bit    gnt_off;
    bit    valid_off;
    int    cycles;
    bit    exp_req;
    int    exp_gnts;    // -1: not checked
    bit    chk_stable;
  } stall_vec_t;

  typedef struct {
    string name;
    int    exp;
  } fin_vec_t;

  stall_vec_t sv [4];
  fin_vec_t   fv [8];
  int         fact [8];

  task automatic pulse_start();
    start = 1'b1;
    @(posedge bird_load_clk); #2;
    start = 1'b0;
  endtask

  initial begin
    int n, g0, cnt_rate;
    logic [23:0] a0;
    bit stable;

    sv[0] = '{"gnt_stall",   1'b1, 1'b0, 10, 1'b1,  0, 1'b1};
    sv[1] = '{"valid_hold",  1'b0, 1'b1, 10, 1'b0,  4, 1'b0};
    sv[2] = '{"both_hold",   1'b1, 1'b1,  5, 1'b0,  0, 1'b0};
    sv[3] = '{"resume",      1'b0, 1'b0, 12, 1'b1, -1, 1'b0};

    fv[0] = '{"bird_strobes", 5250};
    fv[1] = '{"pipe_strobes", PIPE_N};
    fv[2] = '{"base_strobes", 4800};
    fv[3] = '{"last_pipe_addr", PIPE_N - 1};
    fv[4] = '{"done_pulses", 1};
    fv[5] = '{"done_final", 1};
    fv[6] = '{"busy_final", 0};
    fv[7] = '{"rd_req_final", 0};

    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);

    // Reset state
    repeat (3) @(posedge bird_load_clk); #2;
    check_eq("rst_rd_req", longint'(rd_req), 0);
    check_eq("rst_rd_addr", longint'(rd_addr), 0);
    check_eq("rst_strobes", longint'({bird_en, pipe_en, base_en}), 0);
    check_eq("rst_addrs", longint'({bird_addr, pipe_addr, base_addr}), 0);
    check_eq("rst_data", longint'(load_data), 0);
    check_eq("rst_busy_done", longint'({busy, done}), 0);
    rst_n = 1'b1;

    // First load, aborted by reset at pipe word 1234
    @(posedge bird_load_clk); #2;
    pulse_start();
    check_eq("busy_after_start", longint'(busy), 1);
    check_eq("done_after_start", longint'(done), 0);
    n = 0;
    while (!(ph == 1 && idx >= 1235) && n < 20000) begin
      @(posedge bird_load_clk); #2; n++;
    end
    check_eq("reached_pipe_word_1234", (ph == 1 && idx == 1235) ? 1 : 0, 1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("async_rst_rd_req", longint'(rd_req), 0);
    check_eq("async_rst_rd_addr", longint'(rd_addr), 0);
    check_eq("async_rst_pipe_en", longint'(pipe_en), 0);
    check_eq("async_rst_pipe_addr", longint'(pipe_addr), 0);
    check_eq("async_rst_data", longint'(load_data), 0);
    check_eq("async_rst_busy", longint'(busy), 0);
    repeat (2) @(posedge bird_load_clk);
    #3 rst_n = 1'b1;
    expect_none = 1'b1;
    inject_cnt = 3;
    repeat (8) @(posedge bird_load_clk); #2;
    check_eq("stale_valid_strobes", stale_strobes, 0);
    check_eq("stale_busy_done", longint'({busy, done}), 0);
    check_eq("stale_rd_req", longint'(rd_req), 0);
    expect_none = 1'b0;

    // Second load: full sequence from bird address 0
    pulse_start();
    n = 0;
    while (!(ph == 0 && idx >= 100) && n < 2000) begin
      @(posedge bird_load_clk); #2; n++;
    end
    check_eq("reached_bird_word_100", (ph == 0 && idx >= 100) ? 1 : 0, 1);

    for (int v = 0; v < 4; v++) begin
      gnt_en = !sv[v].gnt_off;
      valid_hold = sv[v].valid_off;
      g0 = gnt_total;
      a0 = rd_addr;
      stable = 1'b1;
      for (int c = 0; c < sv[v].cycles; c++) begin
        @(posedge bird_load_clk); #2;
        if (rd_addr != a0 || !rd_req) stable = 1'b0;
      end
      check_eq({sv[v].name, "_rd_req"}, longint'(rd_req), longint'(sv[v].exp_req));
      if (sv[v].exp_gnts >= 0) check_eq({sv[v].name, "_grants"}, gnt_total - g0, sv[v].exp_gnts);
      if (sv[v].chk_stable) check_eq({sv[v].name, "_addr_stable"}, longint'(stable), 1);
    end
    gnt_en = 1'b1;
    valid_hold = 1'b0;

    // Grant and return together every cycle: one strobe per cycle
    n = 0;
    while (!(ph == 1 && idx >= 100) && n < 20000) begin
      @(posedge bird_load_clk); #2; n++;
    end
    check_eq("reached_pipe_word_100", (ph == 1 && idx >= 100) ? 1 : 0, 1);
    cnt_rate = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge bird_load_clk); #2;
      if (pipe_en) cnt_rate++;
    end
    check_eq("strobe_rate_50_cycles", cnt_rate, 50);

    // start while busy is ignored
    pulse_start();
    check_eq("busy_after_ignored_start", longint'(busy), 1);

    // Base phase under random grant and latency
    n = 0;
    while (ph < 2 && n < 60000) begin
      @(posedge bird_load_clk); #2; n++;
    end
    check_eq("reached_base", ph, 2);
    rnd_mode = 1'b1;
    n = 0;
    while (!done && n < 40000) begin
      @(posedge bird_load_clk); #2; n++;
    end
    check_eq("done_reached", longint'(done), 1);
    rnd_mode = 1'b0;
    repeat (10) @(posedge bird_load_clk); #2;

    fact[0] = scnt[0];
    fact[1] = scnt[1];
    fact[2] = scnt[2];
    fact[3] = last_pipe;
    fact[4] = done_pulses;
    fact[5] = int'(done);
    fact[6] = int'(busy);
    fact[7] = int'(rd_req);
    for (int i = 0; i < 8; i++) check_eq(fv[i].name, fact[i], fv[i].exp);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1900000;
    $display("FAIL watchdog: simulation exceeded time limit (%0d/%0d checks passed)", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/texture_loader.md
Name: texture_loader

Overview:
Sequencer directly upstream of sprite_render's texture RAMs. On start, it streams the bird, pipe and base textures out of SDRAM through a word-read request/response port. It then presents each word on the shared load-data bus with the matching per-asset write strobe and address. It runs in the bird_load_clk domain (50 MHz), which is also the write clock of the texture RAMs.

Parameters:
BIRD_SRC_ADDR, 24'h000000, SDRAM word address of bird texture (3 frames, 50x35 each)
PIPE_SRC_ADDR, 24'h001482, SDRAM word address of pipe texture (80x500)
BASE_SRC_ADDR, 24'h00B0C2, SDRAM word address of base texture
BIRD_WORDS, 5250, words fetched for bird
PIPE_WORDS, 40000, words in full pipe texture
PIPE_KEEP_WORDS, 4000, pipe words actually needed (first 50 rows); used only with the optional feature
BASE_WORDS, 4800, words fetched for base (32x150)
MAX_OUTSTANDING, 4, maximum accepted-but-unreturned reads (power of 2, 1..8)

Ports:
bird_load_clk  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begin a full load
rd_req  out  1  SDRAM read request, held until granted
rd_addr  out  24  SDRAM word address, stable while rd_req=1
rd_gnt  in  1  request accepted this cycle
rd_valid  in  1  one read word returned, in request order
rd_data  in  16  returned word
bird_load_en  out  1  bird RAM write strobe
bird_load_addr  out  13  bird RAM address
pipe_load_en  out  1  pipe RAM write strobe
pipe_load_addr  out  16  pipe RAM address
base_load_en  out  1  base RAM write strobe
base_load_addr  out  14  base RAM address
bird_load_data  out  16  shared load data bus for all three RAMs
busy  out  1  load in progress
done  out  1  sticky: all textures loaded

Behaviour:
- Reset values: all outputs 0; FSM state = IDLE; all counters = 0.
- Reset is asynchronous and may assert mid-load. The load aborts and is not resumed. Late rd_valid returns after reset are ignored because outstanding = 0.
- FSM states: IDLE -> BIRD -> PIPE -> BASE -> DONE.
  - IDLE: waits for start. On start, clears done, sets busy, and enters BIRD.
  - Each asset state runs two counters: req_cnt (requests granted) and rsp_cnt (words returned).
  - An asset state exits when rsp_cnt == N and outstanding == 0.
  - The next asset's counters are cleared in the same transition.
  - DONE: sets done=1 and busy=0 for one cycle, then returns to IDLE. done stays high until the next start.
- start while busy is ignored.
- Request rules:
  - rd_req = 1 when req_cnt < N and outstanding < MAX_OUTSTANDING.
  - rd_addr = SRC_ADDR + req_cnt.
  - req_cnt increments on rd_req & rd_gnt.
  - rd_req never drops without a grant, except on reset.
- outstanding update per cycle: +1 on grant, -1 on rd_valid. Both in the same cycle leaves it unchanged.
- rd_valid while outstanding == 0 is a protocol violation and is dropped.
- Response path, latency 1:
  - On rd_valid, in the next cycle: bird_load_data = rd_data, <asset>_load_addr = rsp_cnt (pre-increment value), <asset>_load_en = 1 for exactly 1 cycle.
  - The other two strobes remain 0.
  - Address and data hold their last value when the strobe is 0.
- Address widths: counter values are truncated into the port width. N must fit in the port: 5250 < 2^13, 40000 < 2^16, 4800 < 2^14.
- Counters are 16-bit unsigned.
- SRC_ADDR + count is 24-bit modulo; no wrap is expected within the defined parameters.
- Back-to-back rd_valid every cycle is supported: one strobe per cycle, with no bubble required.

Optional Feature:
TEXTURE_PIPE_TRUNC_EN
- Defined: the PIPE phase uses N = PIPE_KEEP_WORDS. Only the first 4000 pipe words are requested. The last pipe_load_addr is 3999. Total load time drops by about 36000 reads.
- Undefined: N = PIPE_WORDS; all 40000 words are streamed (addresses 0..39999). Filtering of addresses >= 4000 is left to the consumer.

Decomposition:
- Package texture_loader_pkg:
  - FSM state enum: IDLE, BIRD, PIPE, BASE, DONE.
  - Default word counts and source-address constants, shared with sprite_render sizing.
- Natural sub-module: tex_fetch_channel. It holds req_cnt, rsp_cnt and outstanding tracking for one asset phase (inputs: src_addr, count, clear; outputs: rd_req, rd_addr, phase_done, rsp_idx).
- The top-level FSM and strobe demux stay in texture_loader.

Test Plan:
- Reset then start; rd_gnt always 1; rd_valid 2 cycles after each grant:
  - expect 5250 bird strobes (addr 0..5249), then 40000 pipe strobes, then 4800 base strobes.
  - done=1 and busy=0 at the end.
  - Each strobe's data equals the SDRAM model word at SRC+addr.
- rd_gnt low for 10 cycles with rd_req high:
  - rd_addr stays stable and no extra request is counted.
  - Hold rd_valid off: rd_req deasserts after 4 grants (MAX_OUTSTANDING).
- Grant and rd_valid in the same cycle continuously: outstanding stays constant, the strobe rate is 1 per cycle, and no word is lost or duplicated.
- start pulse during the PIPE phase: ignored; the sequence completes normally with a single done.
- rst_n asserted at pipe word 1234:
  - all outputs 0 immediately (asynchronous).
  - 3 stale rd_valid after release produce no strobe.
  - A new start restarts at bird addr 0.
- With TEXTURE_PIPE_TRUNC_EN defined: exactly 4000 pipe strobes, the last pipe_load_addr = 3999, and the base phase begins at pipe word 4000.
